// File: rtl/router_local_ni_pkg.sv
// Shared types for the router LOCAL-port network interface.
// Holds the flit format, the send FSM states and the statistics counter helpers.
package router_local_ni_pkg;

  typedef struct packed {
    logic [3:0]  dst;
    logic [1:0]  kind;
    logic [31:0] payload;
  } generic_flit_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} ni_state_e;

  localparam int NI_STAT_W = 16;

  function automatic logic [NI_STAT_W-1:0] sat_inc(input logic [NI_STAT_W-1:0] v,
                                                   input logic               en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/router_local_ni_fifo.sv
// Power-of-two FIFO with extra-MSB pointers; the caller guarantees no push while
// full unless the same cycle also pops.
module router_local_ni_fifo
  import router_local_ni_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = generic_flit_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("router_local_ni_fifo: DEPTH must be a power of 2 and at least 2");
  end

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/router_local_ni.sv
// Tile-side network interface for a router LOCAL port: req/ack injection with retry,
// no-backpressure ejection buffering. Define NI_STATS_EN to add saturating statistics counters.
module router_local_ni
  import router_local_ni_pkg::*;
#(
  parameter int INJ_DEPTH   = 4,
  parameter int EJ_DEPTH    = 4,
  parameter int RETRY_LIMIT = 15,
  parameter int FLIT_TYPE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inj_valid,
  input  generic_flit_t        inj_flit,
  output logic                 inj_ready,
  output logic                 ej_valid,
  output generic_flit_t        ej_flit,
  input  logic                 ej_ready,
  output logic                 rtr_req,
  output generic_flit_t        rtr_flit,
  input  logic                 rtr_ack,
  input  logic                 rtr_req_in,
  input  generic_flit_t        rtr_flit_in,
  output logic                 rtr_ack_out,
  output logic                 err_timeout,
  output logic                 err_overflow
`ifdef NI_STATS_EN
  ,
  output logic [NI_STAT_W-1:0] stat_inj,
  output logic [NI_STAT_W-1:0] stat_ej,
  output logic [NI_STAT_W-1:0] stat_retry,
  output logic [NI_STAT_W-1:0] stat_drop
`endif
);

  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam int RW  = $clog2(RETRY_LIMIT + 1);

  if ((FLIT_TYPE != 0) && (FLIT_TYPE != 1)) begin : g_bad_flit_type
    $error("router_local_ni: FLIT_TYPE must be 0 (operand) or 1 (mem)");
  end

  ni_state_e     state_q, state_d;
  logic [RW-1:0] retry_cnt;
  logic [IAW:0]  inj_level;
  logic [EAW:0]  ej_level;
  generic_flit_t inj_head, ej_head;
  logic          inj_full, inj_push, inj_more;
  logic          ej_full, ej_push, ej_pop, ej_drop;
  logic          acked, nacked;

  // ---------------- injection ----------------
  assign inj_ready = !inj_full;
  assign inj_push  = inj_valid && !inj_full;
  assign acked     = (state_q == WAIT) &&  rtr_ack;
  assign nacked    = (state_q == WAIT) && !rtr_ack;
  // Something is still queued after this cycle's pop: another entry, or a same-cycle push.
  assign inj_more  = (inj_level > (IAW+1)'(1)) || inj_push;

  router_local_ni_fifo #(.DEPTH(INJ_DEPTH), .T(generic_flit_t)) u_inj_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inj_push),
    .din   (inj_flit),
    .pop   (acked),
    .dout  (inj_head),
    .full  (inj_full),
    .level (inj_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_d = state_q;
    rtr_req = 1'b0;
    case (state_q)
      IDLE: if (inj_level != '0) state_d = SEND;
      SEND: begin
        rtr_req = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!rtr_ack)      state_d = SEND;
        else if (inj_more) state_d = SEND;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head cannot change between SEND and the acked edge, so rtr_flit holds across the attempt.
  assign rtr_flit = (state_q == IDLE) ? generic_flit_t'('0) : inj_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt   <= '0;
      err_timeout <= 1'b0;
    end else if (acked) begin
      retry_cnt <= '0;
    end else if (nacked) begin
      if (retry_cnt != RW'(RETRY_LIMIT))       retry_cnt   <= retry_cnt + 1'b1;
      if (retry_cnt >= RW'(RETRY_LIMIT - 1))   err_timeout <= 1'b1;
    end
  end

  // ---------------- ejection ----------------
  assign ej_valid = (ej_level != '0);
  assign ej_flit  = ej_valid ? ej_head : generic_flit_t'('0);
  assign ej_pop   = ej_valid && ej_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign ej_push  = rtr_req_in && (!ej_full || ej_pop);
  assign ej_drop  = rtr_req_in && ej_full && !ej_pop;

  router_local_ni_fifo #(.DEPTH(EJ_DEPTH), .T(generic_flit_t)) u_ej_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ej_push),
    .din   (rtr_flit_in),
    .pop   (ej_pop),
    .dout  (ej_head),
    .full  (ej_full),
    .level (ej_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_ack_out  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rtr_ack_out <= ej_push;
      if (ej_drop) err_overflow <= 1'b1;
    end
  end

`ifdef NI_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_inj   <= '0;
      stat_ej    <= '0;
      stat_retry <= '0;
      stat_drop  <= '0;
    end else begin
      stat_inj   <= sat_inc(stat_inj,   acked);
      stat_ej    <= sat_inc(stat_ej,    ej_push);
      stat_retry <= sat_inc(stat_retry, nacked);
      stat_drop  <= sat_inc(stat_drop,  ej_drop);
    end
  end
`endif

endmodule

// File: tb/tb_router_local_ni.sv
// Scoreboard bench for router_local_ni: stimulus queues expected flits, a negedge
// monitor compares whatever the DUT presents on the router and tile sides.
module tb_router_local_ni;
  import router_local_ni_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inj_valid = 1'b0, ej_ready = 1'b0;
  logic          rtr_ack = 1'b0, rtr_req_in = 1'b0;
  generic_flit_t inj_flit = '0, rtr_flit_in = '0;
  logic          inj_ready, ej_valid, rtr_req, rtr_ack_out, err_timeout, err_overflow;
  generic_flit_t ej_flit, rtr_flit;
`ifdef NI_STATS_EN
  logic [NI_STAT_W-1:0] stat_inj, stat_ej, stat_retry, stat_drop;
`endif

  always #5 clk = ~clk;

  router_local_ni #(.INJ_DEPTH(4), .EJ_DEPTH(4), .RETRY_LIMIT(15), .FLIT_TYPE(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inj_valid    (inj_valid),
    .inj_flit     (inj_flit),
    .inj_ready    (inj_ready),
    .ej_valid     (ej_valid),
    .ej_flit      (ej_flit),
    .ej_ready     (ej_ready),
    .rtr_req      (rtr_req),
    .rtr_flit     (rtr_flit),
    .rtr_ack      (rtr_ack),
    .rtr_req_in   (rtr_req_in),
    .rtr_flit_in  (rtr_flit_in),
    .rtr_ack_out  (rtr_ack_out),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
`ifdef NI_STATS_EN
    ,
    .stat_inj     (stat_inj),
    .stat_ej      (stat_ej),
    .stat_retry   (stat_retry),
    .stat_drop    (stat_drop)
`endif
  );

  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, req_pulses = 0;
  int            req_cycles[$];
  generic_flit_t exp_inj[$], exp_ej[$];
  generic_flit_t last_flit = '0;
  logic          prev_req = 1'b0, req_seen = 1'b0, ack_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic generic_flit_t mk(input int i);
    generic_flit_t f;
    f.dst     = i[3:0];
    f.kind    = i[5:4];
    f.payload = 32'hA5A0_0000 + i;
    return f;
  endfunction

  always @(posedge clk) cyc++;

  // Router model: registered ack one cycle after each req, when enabled.
  always @(negedge clk) req_seen = rtr_req;
  always @(posedge clk) begin
    #1;
    rtr_ack = ack_en && req_seen && rst_n;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (rtr_req) begin
        req_pulses++;
        req_cycles.push_back(cyc);
        check("req_single_cycle", prev_req, 0);
        check("inj_expected_present", exp_inj.size() != 0, 1);
        if (exp_inj.size() != 0) check("rtr_flit", rtr_flit, exp_inj[0]);
        last_flit = rtr_flit;
      end else if (prev_req) begin
        check("rtr_flit_stable_wait", rtr_flit, last_flit);
      end
      if (rtr_ack && exp_inj.size() != 0) void'(exp_inj.pop_front());
      if (ej_valid && ej_ready) begin
        check("ej_expected_present", exp_ej.size() != 0, 1);
        if (exp_ej.size() != 0) check("ej_flit", ej_flit, exp_ej.pop_front());
      end
      prev_req = rtr_req;
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    ack_en = 1'b0;
    inj_valid = 1'b0;
    rtr_req_in = 1'b0;
    ej_ready = 1'b0;
    exp_inj.delete();
    exp_ej.delete();
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n = 0;
    while (req_pulses < target && n < budget) begin
      at_neg();
      n++;
    end
    check(name, req_pulses >= target, 1);
  endtask

  task automatic inject(input generic_flit_t f);
    check("inj_ready_before_push", inj_ready, 1);
    inj_valid = 1'b1;
    inj_flit  = f;
    exp_inj.push_back(f);
    at_pos();
    inj_valid = 1'b0;
  endtask

  task automatic eject_push(input generic_flit_t f, input logic accept);
    rtr_req_in  = 1'b1;
    rtr_flit_in = f;
    if (accept) exp_ej.push_back(f);
    at_pos();
    rtr_req_in = 1'b0;
    at_neg();
    check("rtr_ack_out", rtr_ack_out, accept);
    at_pos();
  endtask

  initial begin
    int base;
    // Reset state
    enter_reset();
    #12;
    check("rst_inj_ready", inj_ready, 1);
    check("rst_rtr_req", rtr_req, 0);
    check("rst_ej_valid", ej_valid, 0);
    check("rst_rtr_ack_out", rtr_ack_out, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_rtr_flit", rtr_flit, 0);
    check("rst_ej_flit", ej_flit, 0);
    leave_reset();

    // Single flit, immediate ack
    ack_en = 1'b1;
    base = req_pulses;
    inject(mk(1));
    wait_pulses(base + 1, 10, "single_req_seen");
    repeat (2) at_neg();
    check("single_fifo_empty", dut.inj_level, 0);
    check("single_state_idle", dut.state_q, IDLE);
    repeat (3) at_neg();
    check("single_pulse_count", req_pulses - base, 1);
    check("single_sb_drained", exp_inj.size(), 0);

    // Three back-to-back flits, immediate acks
    at_pos();
    base = req_pulses;
    req_cycles.delete();
    inj_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b2b_inj_ready", inj_ready, 1);
      inj_flit = mk(16 + i);
      exp_inj.push_back(mk(16 + i));
      at_pos();
    end
    inj_valid = 1'b0;
    wait_pulses(base + 3, 20, "b2b_reqs_seen");
    if (req_cycles.size() >= 3) begin
      check("b2b_spacing_1", req_cycles[1] - req_cycles[0], 2);
      check("b2b_spacing_2", req_cycles[2] - req_cycles[1], 2);
    end
    repeat (3) at_neg();
    check("b2b_sb_drained", exp_inj.size(), 0);

    // Retry until timeout, then ack
    at_pos();
    ack_en = 1'b0;
    base = req_pulses;
    inject(mk(33));
    wait_pulses(base + 15, 100, "retry_15_seen");
    check("timeout_not_yet", err_timeout, 0);
    wait_pulses(base + 16, 10, "retry_16_seen");
    check("timeout_after_15_fail", err_timeout, 1);
    check("retry_cnt_sat", dut.retry_cnt, 15);
    ack_en = 1'b1;
    repeat (4) at_neg();
    check("retry_total_pulses", req_pulses - base, 16);
    check("retry_sb_drained", exp_inj.size(), 0);
    check("timeout_sticky", err_timeout, 1);
    check("retry_cnt_cleared", dut.retry_cnt, 0);

    // Ejection overflow with ej_ready=0
    enter_reset();
    leave_reset();
    for (int i = 0; i < 5; i++) eject_push(mk(48 + i), i < 4);
    check("overflow_set", err_overflow, 1);
    check("ej_valid_full", ej_valid, 1);
    check("ej_head_first", ej_flit, mk(48));

    // Pop while full with a simultaneous push
    enter_reset();
    leave_reset();
    for (int i = 0; i < 4; i++) eject_push(mk(64 + i), 1'b1);
    check("refill_no_overflow", err_overflow, 0);
    ej_ready    = 1'b1;
    rtr_req_in  = 1'b1;
    rtr_flit_in = mk(70);
    exp_ej.push_back(mk(70));
    at_pos();
    rtr_req_in = 1'b0;
    ej_ready   = 1'b0;
    at_neg();
    check("popfull_ack_out", rtr_ack_out, 1);
    check("popfull_no_overflow", err_overflow, 0);
    check("popfull_still_full", dut.ej_level, 4);
    at_pos();
    ej_ready = 1'b1;
    repeat (6) at_neg();
    check("ej_sb_drained", exp_ej.size(), 0);
    check("ej_empty_after_drain", ej_valid, 0);

    // Reset during WAIT with two flits queued
    at_pos();
    ej_ready = 1'b0;
    eject_push(mk(80), 1'b1);
    base = req_pulses;
    inj_valid = 1'b1;
    inj_flit = mk(90); exp_inj.push_back(mk(90)); at_pos();
    inj_flit = mk(91); exp_inj.push_back(mk(91)); at_pos();
    inj_valid = 1'b0;
    wait_pulses(base + 1, 10, "rstwait_req_seen");
    @(posedge clk);
    #2;
    check("rstwait_state_wait", dut.state_q, WAIT);
    enter_reset();
    #1;
    check("rstwait_req", rtr_req, 0);
    check("rstwait_inj_ready", inj_ready, 1);
    check("rstwait_ej_valid", ej_valid, 0);
    check("rstwait_err_timeout", err_timeout, 0);
    check("rstwait_err_overflow", err_overflow, 0);
    check("rstwait_state_idle", dut.state_q, IDLE);
    leave_reset();

    // Reset while req is high: req must drop without a clock edge
    base = req_pulses;
    inject(mk(99));
    wait_pulses(base + 1, 10, "rstsend_req_seen");
    check("rstsend_req_high", rtr_req, 1);
    enter_reset();
    #1;
    check("rstsend_req_async_drop", rtr_req, 0);
    leave_reset();
    repeat (3) at_neg();
    check("post_reset_no_req", req_pulses - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
